// File: rtl/bank_wr_sched_if.sv
// Bundle of the request side and the two bank SRAM ports of bank_wr_sched.
//   slave  : the scheduler (receives rd/wr requests and do_*; drives ready/valid and bank controls)
//   master : the environment (requester plus the two bank SRAMs)
// Signals: rd_en/rd_adr/rd_ready/rd_valid/rd_data, wr_en/wr_adr/wr_data/wr_ready,
//          wb_count, en_*/we_*/a_*/di_*/do_* for banks 0 and 1.
interface bank_wr_sched_if #(
  parameter int A_W      = 8,
  parameter int D_W      = 32,
  parameter int WB_DEPTH = 4
);
  localparam int C_W = $clog2(WB_DEPTH + 1);

  logic           rd_en;
  logic [A_W-1:0] rd_adr;
  logic           rd_ready;
  logic           rd_valid;
  logic [D_W-1:0] rd_data;
  logic           wr_en;
  logic [A_W-1:0] wr_adr;
  logic [D_W-1:0] wr_data;
  logic           wr_ready;
  logic [C_W-1:0] wb_count;
  logic           en_0, en_1;
  logic           we_0, we_1;
  logic [A_W-2:0] a_0, a_1;
  logic [D_W-1:0] di_0, di_1;
  logic [D_W-1:0] do_0, do_1;

  modport slave (
    input  rd_en, rd_adr, wr_en, wr_adr, wr_data, do_0, do_1,
    output rd_ready, rd_valid, rd_data, wr_ready, wb_count,
           en_0, en_1, we_0, we_1, a_0, a_1, di_0, di_1
  );

  modport master (
    output rd_en, rd_adr, wr_en, wr_adr, wr_data, do_0, do_1,
    input  rd_ready, rd_valid, rd_data, wr_ready, wb_count,
           en_0, en_1, we_0, we_1, a_0, a_1, di_0, di_1
  );
endinterface

// File: rtl/bank_wr_sched.sv
// bank_wr_sched: schedules one read and one write stream onto two single-port
// RAM banks (bank = address bit 0, row = address[A_W-1:1]). Reads always win a
// bank; writes that conflict or queue behind older writes wait in an in-order
// write buffer and retire when their bank is idle. A starvation guard throttles
// reads for one cycle once the buffer head has been blocked STARVE_MAX cycles.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous reset, active-high
//   bus  : bank_wr_sched_if.slave (request side, read return, bank SRAM ports)
// Configuration macro: BANK_SCHED_FWD_EN
//   defined   : reads hitting a buffered write are accepted and return the
//               youngest matching buffered data
//   undefined : reads hitting a buffered write stall until that entry retires
module bank_wr_sched #(
  parameter int A_W        = 8,
  parameter int D_W        = 32,
  parameter int WB_DEPTH   = 4,
  parameter int STARVE_MAX = 8
) (
  input logic            clk,
  input logic            rst,
  bank_wr_sched_if.slave bus
);
  localparam int R_W = A_W - 1;
  localparam int C_W = $clog2(WB_DEPTH + 1);
  localparam int S_W = $clog2(STARVE_MAX + 1);
  localparam int unsigned DEPTH_U = WB_DEPTH;

  // Buffer is a shift register: entry 0 is the head (oldest), valid entries
  // occupy [0, count_q); the youngest valid entry has the highest index.
  logic [A_W-1:0] wb_adr_q [WB_DEPTH];
  logic [A_W-1:0] wb_adr_d [WB_DEPTH];
  logic [D_W-1:0] wb_dat_q [WB_DEPTH];
  logic [D_W-1:0] wb_dat_d [WB_DEPTH];
  logic [C_W-1:0] count_q, count_d;
  logic [S_W-1:0] starve_q, starve_d;
  logic           rd_valid_q, rd_bank_q;
  logic [R_W-1:0] a0_q, a1_q;
  logic [D_W-1:0] di0_q, di1_q;
`ifdef BANK_SCHED_FWD_EN
  logic           rd_fwd_q;
  logic [D_W-1:0] fwd_dat_q, fwd_dat;
`endif

  logic           wb_empty, throttle, rd_match;
  logic           rd_ready, wr_ready, rd_acc, wr_acc;
  logic           rd_bank, head_blk, retire, bypass, enq, wr_go, wr_bank;
  logic [A_W-1:0] wr_sel_adr;
  logic [D_W-1:0] wr_sel_dat;
  logic [C_W-1:0] wr_slot;
  logic           en0, en1, we0, we1;
  logic [R_W-1:0] a0, a1;
  logic [D_W-1:0] di0, di1;

  assign wb_empty = (count_q == '0);
  assign throttle = (starve_q == S_W'(STARVE_MAX));
  assign wr_ready = (count_q < C_W'(WB_DEPTH));

  // Address match against valid entries; the last hit in the scan is the youngest.
  always_comb begin
    rd_match = 1'b0;
`ifdef BANK_SCHED_FWD_EN
    fwd_dat  = '0;
`endif
    for (int unsigned i = 0; i < DEPTH_U; i++) begin
      if (i < 32'(count_q) && wb_adr_q[i] == bus.rd_adr) begin
        rd_match = 1'b1;
`ifdef BANK_SCHED_FWD_EN
        fwd_dat  = wb_dat_q[i];
`endif
      end
    end
  end

`ifdef BANK_SCHED_FWD_EN
  assign rd_ready = !throttle;
`else
  assign rd_ready = !throttle && !rd_match;
`endif

  assign rd_acc  = bus.rd_en && rd_ready;
  assign wr_acc  = bus.wr_en && wr_ready;
  assign rd_bank = bus.rd_adr[0];

  // Only the head may issue from the buffer; the incoming write may only
  // bypass when nothing older is waiting.
  assign head_blk   = !wb_empty && rd_acc && (rd_bank == wb_adr_q[0][0]);
  assign retire     = !wb_empty && !head_blk;
  assign bypass     = wb_empty && wr_acc && !(rd_acc && (rd_bank == bus.wr_adr[0]));
  assign enq        = wr_acc && !bypass;
  assign wr_go      = retire || bypass;
  assign wr_sel_adr = wb_empty ? bus.wr_adr  : wb_adr_q[0];
  assign wr_sel_dat = wb_empty ? bus.wr_data : wb_dat_q[0];
  assign wr_bank    = wr_sel_adr[0];
  assign wr_slot    = count_q - C_W'(retire);

  assign count_d  = count_q - C_W'(retire) + C_W'(enq);
  // Blocked whenever non-empty and not retiring; a throttle cycle forces the retire.
  assign starve_d = (wb_empty || retire) ? '0 : starve_q + S_W'(1);

  always_comb begin
    for (int unsigned i = 0; i < DEPTH_U; i++) begin
      wb_adr_d[i] = wb_adr_q[i];
      wb_dat_d[i] = wb_dat_q[i];
    end
    if (retire) begin
      for (int unsigned i = 0; i + 1 < DEPTH_U; i++) begin
        wb_adr_d[i] = wb_adr_q[i+1];
        wb_dat_d[i] = wb_dat_q[i+1];
      end
    end
    if (enq) begin
      for (int unsigned i = 0; i < DEPTH_U; i++) begin
        if (32'(wr_slot) == i) begin
          wb_adr_d[i] = bus.wr_adr;
          wb_dat_d[i] = bus.wr_data;
        end
      end
    end
  end

  // Bank ports; a read and a write never target the same bank in one cycle.
  always_comb begin
    en0 = 1'b0;
    en1 = 1'b0;
    we0 = 1'b0;
    we1 = 1'b0;
    a0  = a0_q;
    a1  = a1_q;
    di0 = di0_q;
    di1 = di1_q;
    if (!rst) begin
      if (rd_acc && !rd_bank) begin
        en0 = 1'b1;
        a0  = bus.rd_adr[A_W-1:1];
      end
      if (rd_acc && rd_bank) begin
        en1 = 1'b1;
        a1  = bus.rd_adr[A_W-1:1];
      end
      if (wr_go && !wr_bank) begin
        en0 = 1'b1;
        we0 = 1'b1;
        a0  = wr_sel_adr[A_W-1:1];
        di0 = wr_sel_dat;
      end
      if (wr_go && wr_bank) begin
        en1 = 1'b1;
        we1 = 1'b1;
        a1  = wr_sel_adr[A_W-1:1];
        di1 = wr_sel_dat;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      starve_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_bank_q  <= 1'b0;
      a0_q       <= '0;
      a1_q       <= '0;
      di0_q      <= '0;
      di1_q      <= '0;
`ifdef BANK_SCHED_FWD_EN
      rd_fwd_q   <= 1'b0;
      fwd_dat_q  <= '0;
`endif
    end else begin
      count_q    <= count_d;
      starve_q   <= starve_d;
      rd_valid_q <= rd_acc;
      rd_bank_q  <= rd_bank;
      a0_q       <= a0;
      a1_q       <= a1;
      di0_q      <= di0;
      di1_q      <= di1;
`ifdef BANK_SCHED_FWD_EN
      rd_fwd_q   <= rd_match;
      fwd_dat_q  <= fwd_dat;
`endif
    end
  end

  // Entry payloads need no reset: validity comes from count_q alone.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < DEPTH_U; i++) begin
      wb_adr_q[i] <= wb_adr_d[i];
      wb_dat_q[i] <= wb_dat_d[i];
    end
  end

  assign bus.rd_ready = rd_ready;
  assign bus.wr_ready = wr_ready;
  assign bus.wb_count = count_q;
  assign bus.rd_valid = rd_valid_q;
`ifdef BANK_SCHED_FWD_EN
  assign bus.rd_data  = !rd_valid_q ? '0 :
                        (rd_fwd_q ? fwd_dat_q : (rd_bank_q ? bus.do_1 : bus.do_0));
`else
  assign bus.rd_data  = !rd_valid_q ? '0 : (rd_bank_q ? bus.do_1 : bus.do_0);
`endif
  assign bus.en_0 = en0;
  assign bus.en_1 = en1;
  assign bus.we_0 = we0;
  assign bus.we_1 = we1;
  assign bus.a_0  = a0;
  assign bus.a_1  = a1;
  assign bus.di_0 = di0;
  assign bus.di_1 = di1;
endmodule

// File: tb/tb_bank_wr_sched.sv
// Directed testbench for bank_wr_sched with two behavioural bank SRAMs.
// Bank 0 row r initially holds 0xB000_0000|r, bank 1 row r holds 0xC000_0000|r.
module tb_bank_wr_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_init = 1'b1;
  int   n_chk = 0;
  int   n_pass = 0;

  bank_wr_sched_if #(.A_W(8), .D_W(32), .WB_DEPTH(4)) bus ();

  bank_wr_sched #(.A_W(8), .D_W(32), .WB_DEPTH(4), .STARVE_MAX(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem0 [128];
  logic [31:0] mem1 [128];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 128; i++) begin
        mem0[i] <= 32'hB000_0000 | 32'(i);
        mem1[i] <= 32'hC000_0000 | 32'(i);
      end
    end else begin
      if (bus.en_0) begin
        if (bus.we_0) mem0[bus.a_0] <= bus.di_0;
        else          bus.do_0      <= mem0[bus.a_0];
      end
      if (bus.en_1) begin
        if (bus.we_1) mem1[bus.a_1] <= bus.di_1;
        else          bus.do_1      <= mem1[bus.a_1];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic re, input logic [7:0] ra, input logic we,
                      input logic [7:0] wa, input logic [31:0] wd);
    @(negedge clk);
    bus.rd_en   = re;
    bus.rd_adr  = ra;
    bus.wr_en   = we;
    bus.wr_adr  = wa;
    bus.wr_data = wd;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 8'h00, 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.rd_en = 1'b0; bus.rd_adr = '0; bus.wr_en = 1'b0; bus.wr_adr = '0; bus.wr_data = '0;
    tick();
    mem_init = 1'b0;

    // Reset state
    idle();
    chk("rst_count",    64'(bus.wb_count), 64'd0);
    chk("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    chk("rst_rd_data",  64'(bus.rd_data),  64'd0);
    chk("rst_en",       64'({bus.en_0, bus.en_1, bus.we_0, bus.we_1}), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("rst_rd_ready", 64'(bus.rd_ready), 64'd1);

    // Read 0x04 and write 0x07 in parallel on different banks
    step(1'b1, 8'h04, 1'b1, 8'h07, 32'h1111_1111);
    chk("par_en0",  64'({bus.en_0, bus.we_0}), 64'b10);
    chk("par_a0",   64'(bus.a_0), 64'h02);
    chk("par_en1",  64'({bus.en_1, bus.we_1}), 64'b11);
    chk("par_a1",   64'(bus.a_1), 64'h03);
    chk("par_di1",  64'(bus.di_1), 64'h1111_1111);
    tick();
    chk("par_count", 64'(bus.wb_count), 64'd0);
    chk("par_valid", 64'(bus.rd_valid), 64'd1);
    chk("par_data",  64'(bus.rd_data), 64'hB000_0002);

    // Conflicting write is buffered, then retires on an idle cycle
    step(1'b1, 8'h02, 1'b1, 8'h06, 32'hA5A5_A5A5);
    chk("cf_en0", 64'({bus.en_0, bus.we_0}), 64'b10);
    chk("cf_a0",  64'(bus.a_0), 64'h01);
    tick();
    chk("cf_count", 64'(bus.wb_count), 64'd1);
    chk("cf_data",  64'(bus.rd_data), 64'hB000_0001);
    idle();
    chk("cf_we0", 64'({bus.en_0, bus.we_0}), 64'b11);
    chk("cf_a0r", 64'(bus.a_0), 64'h03);
    chk("cf_di0", 64'(bus.di_0), 64'hA5A5_A5A5);
    tick();
    chk("cf_count0", 64'(bus.wb_count), 64'd0);
    chk("cf_valid0", 64'(bus.rd_valid), 64'd0);
    chk("cf_data0",  64'(bus.rd_data), 64'd0);
    step(1'b1, 8'h07, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rb_07", 64'(bus.rd_data), 64'h1111_1111);
    step(1'b1, 8'h06, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rb_06", 64'(bus.rd_data), 64'hA5A5_A5A5);

    // Continuous bank-0 reads vs five bank-0 writes: fill, starve, throttle
    for (int c = 0; c < 12; c++) begin
      int w;
      int cnt;
      w   = (c < 4) ? c : 4;
      cnt = (c <= 4) ? c : ((c <= 9) ? 4 : ((c == 10) ? 3 : 4));
      step(1'b1, 8'h20 + 8'(2 * c), (c <= 10), 8'h40 + 8'(2 * w), 32'hD0 + 32'(w));
      chk("stv_count",    64'(bus.wb_count), 64'(cnt));
      chk("stv_wr_ready", 64'(bus.wr_ready), 64'(cnt < 4));
      chk("stv_rd_ready", 64'(bus.rd_ready), 64'(c != 9));
      chk("stv_we0",      64'(bus.we_0),     64'(c == 9));
      if (c == 9) begin
        chk("stv_a0",  64'(bus.a_0),  64'h20);
        chk("stv_di0", 64'(bus.di_0), 64'hD0);
      end
      tick();
      chk("stv_valid", 64'(bus.rd_valid), 64'(c != 9));
      chk("stv_data",  64'(bus.rd_data),  (c != 9) ? 64'hB000_0010 + 64'(c) : 64'd0);
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      chk("drn_we0", 64'(bus.we_0), 64'd1);
      chk("drn_a0",  64'(bus.a_0),  64'h21 + 64'(k));
      chk("drn_di0", 64'(bus.di_0), 64'hD1 + 64'(k));
      tick();
      chk("drn_count", 64'(bus.wb_count), 64'(3 - k));
    end
    step(1'b1, 8'h40, 1'b0, 8'h00, 32'h0);
    tick();
    chk("rb_40", 64'(bus.rd_data), 64'hD0);

    // Read hitting a buffered write
    step(1'b1, 8'h00, 1'b1, 8'h10, 32'h1234_5678);
    tick();
    chk("hit_count", 64'(bus.wb_count), 64'd1);
    step(1'b1, 8'h10, 1'b0, 8'h00, 32'h0);
`ifdef BANK_SCHED_FWD_EN
    chk("fwd_rd_ready", 64'(bus.rd_ready), 64'd1);
    chk("fwd_en0",      64'({bus.en_0, bus.we_0}), 64'b10);
    tick();
    chk("fwd_valid", 64'(bus.rd_valid), 64'd1);
    chk("fwd_data",  64'(bus.rd_data),  64'h1234_5678);
    chk("fwd_count", 64'(bus.wb_count), 64'd1);
    idle();
    chk("fwd_we0", 64'({bus.en_0, bus.we_0}), 64'b11);
    chk("fwd_a0",  64'(bus.a_0), 64'h08);
    tick();
    chk("fwd_count0", 64'(bus.wb_count), 64'd0);
`else
    chk("stl_rd_ready", 64'(bus.rd_ready), 64'd0);
    chk("stl_we0",      64'({bus.en_0, bus.we_0}), 64'b11);
    chk("stl_a0",       64'(bus.a_0), 64'h08);
    tick();
    chk("stl_valid", 64'(bus.rd_valid), 64'd0);
    chk("stl_count", 64'(bus.wb_count), 64'd0);
    step(1'b1, 8'h10, 1'b0, 8'h00, 32'h0);
    chk("stl_rd_ready1", 64'(bus.rd_ready), 64'd1);
    chk("stl_en0",       64'({bus.en_0, bus.we_0}), 64'b10);
    tick();
    chk("stl_valid1", 64'(bus.rd_valid), 64'd1);
    chk("stl_data",   64'(bus.rd_data),  64'h1234_5678);
`endif

    // Two writes to the same address retire in order
    step(1'b1, 8'h00, 1'b1, 8'h08, 32'h1);
    tick();
    chk("ord_count1", 64'(bus.wb_count), 64'd1);
    step(1'b1, 8'h02, 1'b1, 8'h08, 32'h2);
    tick();
    chk("ord_count2", 64'(bus.wb_count), 64'd2);
    idle();
    chk("ord_di_first", 64'(bus.di_0), 64'h1);
    tick();
    idle();
    chk("ord_di_second", 64'(bus.di_0), 64'h2);
    tick();
    chk("ord_count0", 64'(bus.wb_count), 64'd0);
    step(1'b1, 8'h08, 1'b0, 8'h00, 32'h0);
    tick();
    chk("ord_data", 64'(bus.rd_data), 64'h2);

    // Three queued writes, retire+enqueue at WB_DEPTH-1, then mid-run reset
    step(1'b1, 8'h00, 1'b1, 8'h0A, 32'hE1);
    tick();
    step(1'b1, 8'h02, 1'b1, 8'h0C, 32'hE2);
    tick();
    step(1'b1, 8'h04, 1'b1, 8'h0E, 32'hE3);
    tick();
    chk("q3_count", 64'(bus.wb_count), 64'd3);
    step(1'b0, 8'h00, 1'b1, 8'h11, 32'hF1);
    chk("q3_wr_ready", 64'(bus.wr_ready), 64'd1);
    chk("q3_we0",      64'({bus.en_0, bus.we_0, bus.en_1}), 64'b110);
    chk("q3_a0",       64'(bus.a_0), 64'h05);
    tick();
    chk("q3_count_keep", 64'(bus.wb_count), 64'd3);
    step(1'b1, 8'h06, 1'b0, 8'h00, 32'h0);
    tick();
    chk("q3_valid", 64'(bus.rd_valid), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    chk("mr_count", 64'(bus.wb_count), 64'd0);
    chk("mr_valid", 64'(bus.rd_valid), 64'd0);
    chk("mr_data",  64'(bus.rd_data),  64'd0);
    chk("mr_en",    64'({bus.en_0, bus.en_1, bus.we_0, bus.we_1}), 64'd0);
    for (int k = 0; k < 2; k++) begin
      idle();
      chk("mr_we", 64'({bus.we_0, bus.we_1}), 64'd0);
      tick();
    end
    rst = 1'b0;
    idle();
    chk("mr_we_after", 64'({bus.en_0, bus.en_1, bus.we_0, bus.we_1}), 64'd0);
    tick();
    chk("mr_count_after", 64'(bus.wb_count), 64'd0);
    step(1'b1, 8'h0A, 1'b0, 8'h00, 32'h0);
    tick();
    chk("mr_rb_0A", 64'(bus.rd_data), 64'hE1);
    step(1'b1, 8'h0C, 1'b0, 8'h00, 32'h0);
    tick();
    chk("mr_rb_0C", 64'(bus.rd_data), 64'hB000_0006);
    step(1'b1, 8'h0E, 1'b0, 8'h00, 32'h0);
    tick();
    chk("mr_rb_0E", 64'(bus.rd_data), 64'hB000_0007);
    step(1'b1, 8'h11, 1'b0, 8'h00, 32'h0);
    tick();
    chk("mr_rb_11", 64'(bus.rd_data), 64'hC000_0008);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
